sync_fifo_vr: RTL and testbench

//  Parametrised single-clock FIFO with valid/ready on both sides, for buffering between same-clock pipeline stages.

---
 rtl/sync_fifo_vr_pkg.sv | 16 +
 rtl/sync_fifo_vr_if.sv | 43 ++++
 rtl/sync_fifo_vr_ram.sv | 25 ++
 rtl/sync_fifo_vr.sv | 100 ++++++++++
 tb/tb_sync_fifo_vr.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_vr_pkg.sv
// Shared constants and helpers for the sync_fifo_vr FIFO.
// The optional drop counter is enabled with `SYNC_FIFO_DROP_CNT_EN.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_W = 10;
  localparam int DEFAULT_DEPTH  = 64;
  localparam int DROP_CNT_W     = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_vr_if.sv
// Valid/ready bus bundle between a producer/consumer and sync_fifo_vr.
// Carries drop_cnt only when `SYNC_FIFO_DROP_CNT_EN is defined.
interface sync_fifo_vr_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0]     in_data;
  logic                  in_vld;
  logic                  in_rdy;
  logic [DATA_W-1:0]     out_data;
  logic                  out_vld;
  logic                  out_rdy;
  logic [AW:0]           level;
  logic                  afull;
  logic                  aempty;
  logic                  ovf;
  logic                  clr_ovf;
`ifdef SYNC_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;
`endif

  modport master (
    output in_data, in_vld, out_rdy, clr_ovf,
    input  in_rdy, out_data, out_vld, level, afull, aempty, ovf
`ifdef SYNC_FIFO_DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  in_data, in_vld, out_rdy, clr_ovf,
    output in_rdy, out_data, out_vld, level, afull, aempty, ovf
`ifdef SYNC_FIFO_DROP_CNT_EN
    , output drop_cnt
`endif
  );

endinterface

// File: rtl/sync_fifo_vr_ram.sv
// DEPTH x DATA_W storage for sync_fifo_vr: synchronous write, asynchronous read.
// Not reset; the top level masks the read data while the FIFO is empty.
module sfifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_vr.sv
// Single-clock valid/ready FIFO with level, almost-full/almost-empty flags and sticky overflow.
// Defining `SYNC_FIFO_DROP_CNT_EN adds a saturating 16-bit drop counter.
module sync_fifo_vr
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AFULL_TH = 61,
  parameter int AEMPT_TH = 2
) (
  input logic           clk,
  input logic           rst,
  sync_fifo_vr_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] AFULL_LV = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPT_LV = (AW+1)'(AEMPT_TH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  logic [AW:0]       wr_ptr, rd_ptr, level_q, level_nxt;
  logic              full, empty, wr, rd, drop;
  logic              afull_q, aempty_q, ovf_q;
  logic [DATA_W-1:0] rdata;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr    = bus.in_vld && !full;
  assign rd    = bus.out_rdy && !empty;
  assign drop  = bus.in_vld && full;

  always_comb begin
    level_nxt = level_q;
    case ({wr, rd})
      2'b10:   level_nxt = level_q + ONE;
      2'b01:   level_nxt = level_q - ONE;
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + {{AW{1'b0}}, wr};
      rd_ptr   <= rd_ptr + {{AW{1'b0}}, rd};
      level_q  <= level_nxt;
      afull_q  <= (level_nxt >= AFULL_LV);
      aempty_q <= (level_nxt <= AEMPT_LV);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              ovf_q <= 1'b1;
      else if (bus.clr_ovf)  ovf_q <= 1'b0;
    end
  end

  sfifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr && !rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign bus.in_rdy   = !full;
  assign bus.out_vld  = !empty;
  assign bus.out_data = empty ? '0 : rdata;
  assign bus.level    = level_q;
  assign bus.afull    = afull_q;
  assign bus.aempty   = aempty_q;
  assign bus.ovf      = ovf_q;

`ifdef SYNC_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Clear and count in one cycle leaves the counter at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (bus.clr_ovf)          drop_cnt_q <= DROP_CNT_W'(1);
      else if (&drop_cnt_q == 1'b0) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end else if (bus.clr_ovf) begin
      drop_cnt_q <= '0;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_vr.sv
// Randomised self-checking bench for sync_fifo_vr against a queue-based reference model.
// Also checks drop_cnt when `SYNC_FIFO_DROP_CNT_EN is defined.
module tb_sync_fifo_vr;

  localparam int DATA_W   = 10;
  localparam int DEPTH    = 64;
  localparam int AFULL_TH = 61;
  localparam int AEMPT_TH = 2;

  logic clk;
  logic rst;

  sync_fifo_vr_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_vr #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH),
    .AEMPT_TH (AEMPT_TH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared;
  int n_mismatched;
  int q[$];
  bit m_ovf;
  int m_drop;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive, compare every output against the model mid-cycle, then advance the model.
  task automatic applyStimulus(input bit vld, input int data, input bit ordy, input bit clr, input bit r);
    bit can_wr, can_rd, dropped;
    bus.in_vld  = vld;
    bus.in_data = DATA_W'(data);
    bus.out_rdy = ordy;
    bus.clr_ovf = clr;
    rst         = r;
    @(negedge clk);
    checkOutput("level",    32'(bus.level),    32'(q.size()));
    checkOutput("in_rdy",   32'(bus.in_rdy),   32'(q.size() < DEPTH));
    checkOutput("out_vld",  32'(bus.out_vld),  32'(q.size() > 0));
    checkOutput("out_data", 32'(bus.out_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    checkOutput("afull",    32'(bus.afull),    32'(q.size() >= AFULL_TH));
    checkOutput("aempty",   32'(bus.aempty),   32'(q.size() <= AEMPT_TH));
    checkOutput("ovf",      32'(bus.ovf),      32'(m_ovf));
`ifdef SYNC_FIFO_DROP_CNT_EN
    checkOutput("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
`endif
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      can_wr  = q.size() < DEPTH;
      can_rd  = q.size() > 0;
      dropped = vld && !can_wr;
      if (ordy && can_rd) void'(q.pop_front());
      if (vld && can_wr) q.push_back(data & ((1 << DATA_W) - 1));
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (dropped) m_drop = clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
      else if (clr) m_drop = 0;
    end
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    m_ovf        = 1'b0;
    m_drop       = 0;
    bus.in_vld   = 1'b0;
    bus.in_data  = '0;
    bus.out_rdy  = 1'b0;
    bus.clr_ovf  = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset and idle
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_level",  32'(bus.level),  32'd0);
    checkOutput("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    checkOutput("rst_aempty", 32'(bus.aempty), 32'd1);
    checkOutput("rst_afull",  32'(bus.afull),  32'd0);

    // Fill to the almost-full threshold, then to full
    for (int i = 1; i <= 61; i++) begin
      applyStimulus(1, i, 0, 0, 0);
      if (i == 60) checkOutput("afull_at_60", 32'(bus.afull), 32'd0);
    end
    checkOutput("afull_at_61", 32'(bus.afull), 32'd1);
    checkOutput("level_61",    32'(bus.level), 32'd61);
    for (int i = 62; i <= 64; i++) applyStimulus(1, i, 0, 0, 0);
    checkOutput("full_in_rdy", 32'(bus.in_rdy), 32'd0);
    checkOutput("full_level",  32'(bus.level),  32'd64);

    // Overflow when full; a simultaneous clear loses to the set
    applyStimulus(1, 'h3FF, 0, 0, 0);
    checkOutput("ovf_set",   32'(bus.ovf),   32'd1);
    checkOutput("ovf_level", 32'(bus.level), 32'd64);
    applyStimulus(1, 'h3FF, 0, 1, 0);
    checkOutput("ovf_set_wins", 32'(bus.ovf), 32'd1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("ovf_clear", 32'(bus.ovf), 32'd0);

    // Drain in order
    for (int i = 1; i <= 64; i++) begin
      checkOutput("drain_data", 32'(bus.out_data), 32'(i));
      applyStimulus(0, 0, 1, 0, 0);
    end
    checkOutput("drained_vld",  32'(bus.out_vld), 32'd0);
    checkOutput("drained_data", 32'(bus.out_data), 32'd0);

    // Streaming from empty, pointers wrap several times
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1, k + 7, 1, 0, 0);
      if (k == 100) checkOutput("stream_level", 32'(bus.level), 32'd1);
    end
    checkOutput("stream_head", 32'(bus.out_data), 32'(206));
    checkOutput("stream_ovf",  32'(bus.ovf),      32'd0);
    applyStimulus(0, 0, 1, 0, 0);

    // Full with read and write together: read wins, write blocked
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, $urandom_range(0, 1023), 0, 0, 0);
    applyStimulus(1, 'h2AA, 1, 0, 0);
    checkOutput("rdwr_full_level",  32'(bus.level),  32'd63);
    checkOutput("rdwr_full_in_rdy", 32'(bus.in_rdy), 32'd1);
    applyStimulus(0, 0, 0, 1, 0);

    // Reset mid-transfer with a word presented
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 'h100 + i, 0, 0, 0);
    applyStimulus(1, 'h155, 0, 0, 1);
    checkOutput("midrst_level", 32'(bus.level),   32'd0);
    checkOutput("midrst_vld",   32'(bus.out_vld), 32'd0);
    applyStimulus(0, 0, 1, 0, 0);

    // Random traffic, alternating fill-biased and drain-biased segments
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 250; c++) begin
        applyStimulus(($urandom_range(0, 99) < ((seg % 2 == 0) ? 85 : 30)),
                      $urandom_range(0, 1023),
                      ($urandom_range(0, 99) < ((seg % 2 == 0) ? 30 : 85)),
                      ($urandom_range(0, 99) < 5),
                      ($urandom_range(0, 999) < 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
